// File: rtl/sensor_fifo_bridge_pkg.sv
// Shared types and field layout for the host-FIFO-to-sensor bridge.
// Command: [DATA_W-1 -: 8]=channel, rest=payload. Response: status, channel[5:0], data.
package sensor_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_PUSH
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BADCH   = 2'b10
  } status_t;

  localparam int CH_W  = 8;  // channel field in a command word
  localparam int ST_W  = 2;  // status field in a response word
  localparam int RCH_W = 6;  // channel field in a response word

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sensor_fifo_bridge_if.sv
// Host FIFO pair plus per-channel sensor signals; the bridge is the slave side.
interface sensor_fifo_bridge_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
);
  logic [DATA_W-1:0]             din;
  logic                          wr_en;
  logic                          full;
  logic                          rd_en;
  logic [DATA_W-1:0]             dout;
  logic                          empty;
  logic [NUM_CH-1:0][DATA_W-1:0] sns_req;
  logic [NUM_CH-1:0]             sns_req_valid;
  logic [NUM_CH-1:0]             sns_busy;
  logic [NUM_CH-1:0][DATA_W-1:0] sns_data;
  logic [NUM_CH-1:0]             sns_finish;

  modport slave (
    input  din, wr_en, rd_en, sns_busy, sns_data, sns_finish,
    output full, dout, empty, sns_req, sns_req_valid
  );

  modport master (
    output din, wr_en, rd_en, sns_busy, sns_data, sns_finish,
    input  full, dout, empty, sns_req, sns_req_valid
  );
endinterface

// File: rtl/sensor_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after i_rd_en).
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo
  import sensor_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 512
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_full,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_empty
);
  localparam int AW = clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [DATA_W-1:0] r_dout;
  logic              w_wr;
  logic              w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;
  assign o_dout  = r_dout;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  // Flushing only the pointers is enough; stale memory contents are never read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
        r_dout <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/sensor_fifo_bridge.sv
// Pops host commands, dispatches each to one sensor channel, waits for finish or
// timeout, and pushes one tagged response. One command in flight at a time.
module sensor_fifo_bridge
  import sensor_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 512,
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 8_000_000
) (
  input logic                i_clk,
  input logic                i_rst_n,
  sensor_fifo_bridge_if.slave bus
);
  localparam int PL_W  = DATA_W - CH_W;
  localparam int SEL_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int CNT_W = clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t                        r_state;
  logic [DATA_W-1:0]             r_cmd;
  logic [CNT_W-1:0]              r_cnt;
  status_t                       r_status;
  logic [PL_W-1:0]               r_rdata;
  logic [NUM_CH-1:0][DATA_W-1:0] r_req;
  logic [NUM_CH-1:0]             r_req_vld;

  logic              w_in_empty;
  logic [DATA_W-1:0] w_in_dout;
  logic              w_out_full;
  logic              w_pop;
  logic              w_push;
  logic [CH_W-1:0]   w_ch;
  logic [SEL_W-1:0]  w_sel;
  logic              w_bad;
  logic [DATA_W-1:0] w_resp;

  assign w_ch   = r_cmd[DATA_W-1 -: CH_W];
  assign w_sel  = w_ch[SEL_W-1:0];
  assign w_bad  = (w_ch >= CH_W'(NUM_CH));
  assign w_pop  = (r_state == S_IDLE) && !w_in_empty;
  assign w_push = (r_state == S_PUSH) && !w_out_full;
  assign w_resp = {r_status, w_ch[RCH_W-1:0], r_rdata};

  assign bus.sns_req       = r_req;
  assign bus.sns_req_valid = r_req_vld;

  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_in_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr_en (bus.wr_en),
    .i_din   (bus.din),
    .o_full  (bus.full),
    .i_rd_en (w_pop),
    .o_dout  (w_in_dout),
    .o_empty (w_in_empty)
  );

  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr_en (w_push),
    .i_din   (w_resp),
    .o_full  (w_out_full),
    .i_rd_en (bus.rd_en),
    .o_dout  (bus.dout),
    .o_empty (bus.empty)
  );

  // Request strobe is set on entry to ISSUE so it is high for exactly that cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cmd     <= '0;
      r_cnt     <= '0;
      r_status  <= ST_OK;
      r_rdata   <= '0;
      r_req     <= '0;
      r_req_vld <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_in_empty) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_cmd   <= w_in_dout;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_bad) begin
            r_status <= ST_BADCH;
            r_rdata  <= '0;
            r_state  <= S_PUSH;
          end else if (!bus.sns_busy[w_sel]) begin
            r_req[w_sel]     <= {{CH_W{1'b0}}, r_cmd[PL_W-1:0]};
            r_req_vld[w_sel] <= 1'b1;
            r_state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_req_vld <= '0;
          r_cnt     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // Finish is checked first so it wins over a coincident timeout.
          if (bus.sns_finish[w_sel]) begin
            r_status <= ST_OK;
            r_rdata  <= bus.sns_data[w_sel][PL_W-1:0];
            r_state  <= S_PUSH;
          end else if (r_cnt == CNT_LAST) begin
            r_status <= ST_TIMEOUT;
            r_rdata  <= '0;
            r_state  <= S_PUSH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PUSH: begin
          if (!w_out_full) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
